spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 133 +++++++++++++
 tb/tb_spi_slave_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave: synchronizes sclk/cs/mosi into clk, discards LEAD_BITS
// leading samples, then shifts DATA_W bits in LSB first on sclk falling edges.
module spi_slave_rx #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LEAD_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + LEAD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_LEAD = CNT_W'((LEAD_BITS == 0) ? 0 : LEAD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(LEAD_BITS + DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, HOLD} state_t;

  logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic              r_cs_s1, r_cs_s2, r_cs_s3;
  logic              r_mosi_s1, r_mosi_s2;
  logic [1:0]        r_fill;
  logic              r_armed;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_err, w_err_nxt;
  logic              w_sclk_fall, w_cs_fall, w_cs_rise, w_sample;

  // The cs stages reset to 1, so a cs held low through reset would look like a
  // falling edge; r_armed only permits a frame once a real high cs was seen.
  assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;
  assign w_cs_fall   = r_cs_s3 & ~r_cs_s2 & r_armed;
  assign w_cs_rise   = ~r_cs_s3 & r_cs_s2;
  assign w_sample    = w_sclk_fall & ~r_cs_s2;
  assign w_shift_in  = {r_mosi_s2, r_shift[DATA_W-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state_nxt = (LEAD_BITS == 0) ? SHIFT : LEAD;
      end
      LEAD: begin
        if (w_cs_rise) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sample) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_LEAD) w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sample) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_dout_nxt  = w_shift_in;
            w_valid_nxt = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == IDLE) begin
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_fill    <= '0;
      r_armed   <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_fill    <= {r_fill[0], 1'b1};
      r_armed   <= r_armed | (r_fill[1] & r_cs_s2);
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_dout    <= w_dout_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = (r_state == LEAD) || (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of frames (full, aborted, over-long)
// plus hand sequences for cs low at reset release and reset mid-frame.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs, mosi;
  logic [11:0] dout;
  logic        valid, busy, err;

  spi_slave_rx #(.DATA_W(12), .LEAD_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned valid_hi = 0, valid_rise = 0, err_hi = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid) valid_hi++;
    if (valid && !prev_valid) valid_rise++;
    if (err) err_hi++;
    prev_valid = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // edge 0 is the lead bit (driven 1 so it must be discarded), edge i is data bit i-1
  task automatic send_bits(input logic [11:0] d, input int unsigned edges);
    logic b;
    for (int unsigned i = 0; i < edges; i++) begin
      if (i == 0)       b = 1'b1;
      else if (i <= 12) b = d[i-1];
      else              b = 1'b1;
      mosi = b;
      sclk = 1'b1;
      wait_clk(11);
      sclk = 1'b0;
      wait_clk(11);
    end
  endtask

  typedef struct {
    logic [11:0] data;
    int unsigned edges;
    int unsigned exp_valid;
    int unsigned exp_err;
    logic [11:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int unsigned v0, vr0, e0;

    vecs[0] = '{12'hA5C, 13, 1, 0, 12'hA5C};
    vecs[1] = '{12'h001, 13, 1, 0, 12'h001};
    vecs[2] = '{12'hFFF, 13, 1, 0, 12'hFFF};
    vecs[3] = '{12'h3C3,  6, 0, 1, 12'hFFF};
    vecs[4] = '{12'h5A6, 17, 1, 0, 12'h5A6};
    vecs[5] = '{12'h000,  0, 0, 1, 12'h5A6};
    vecs[6] = '{12'h800, 13, 1, 0, 12'h800};
    vecs[7] = '{12'h7FF, 12, 0, 1, 12'h800};
    vecs[8] = '{12'h123, 13, 1, 0, 12'h123};

    rst_n = 1'b0; cs = 1'b0; sclk = 1'b0; mosi = 1'b0;
    wait_clk(3);
    chk("reset_dout",  32'(dout),  32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_err",   32'(err),   32'h0);

    // cs already low when reset releases: no frame may start
    rst_n = 1'b1;
    wait_clk(5);
    send_bits(12'hA5C, 13);
    wait_clk(11);
    chk("csLowAtReset_valid", valid_hi, 0);
    chk("csLowAtReset_busy",  32'(busy), 32'h0);
    chk("csLowAtReset_dout",  32'(dout), 32'h0);
    cs = 1'b1;
    wait_clk(10);
    chk("csLowAtReset_err", err_hi, 0);

    for (int unsigned k = 0; k < 9; k++) begin
      v0 = valid_hi; vr0 = valid_rise; e0 = err_hi;
      cs = 1'b0;
      wait_clk(5);
      send_bits(vecs[k].data, vecs[k].edges);
      wait_clk(11);
      chk($sformatf("v%0d_busy_mid", k), 32'(busy), (vecs[k].edges < 13) ? 32'h1 : 32'h0);
      cs = 1'b1;
      wait_clk(10);
      chk($sformatf("v%0d_valid_pulses", k), valid_rise - vr0, vecs[k].exp_valid);
      chk($sformatf("v%0d_valid_cycles", k), valid_hi - v0,    vecs[k].exp_valid);
      chk($sformatf("v%0d_err_cycles", k),   err_hi - e0,      vecs[k].exp_err);
      chk($sformatf("v%0d_dout", k),         32'(dout),        32'(vecs[k].exp_dout));
      chk($sformatf("v%0d_busy_after", k),   32'(busy),        32'h0);
    end

    // reset mid-frame with cs held low: frame dropped silently, dout cleared
    v0 = valid_hi; e0 = err_hi;
    cs = 1'b0;
    wait_clk(5);
    send_bits(12'hABC, 6);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    send_bits(12'hABC, 7);
    wait_clk(11);
    chk("midReset_valid", valid_hi - v0, 0);
    chk("midReset_busy",  32'(busy), 32'h0);
    chk("midReset_dout",  32'(dout), 32'h0);
    cs = 1'b1;
    wait_clk(10);
    chk("midReset_err", err_hi - e0, 0);

    v0 = valid_hi; e0 = err_hi;
    cs = 1'b0;
    wait_clk(5);
    send_bits(12'h9C3, 13);
    wait_clk(11);
    cs = 1'b1;
    wait_clk(10);
    chk("afterReset_valid", valid_hi - v0, 1);
    chk("afterReset_err",   err_hi - e0,   0);
    chk("afterReset_dout",  32'(dout),     32'h9C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
